// File: rtl/if_fetch.sv
// Instruction fetch stage: owns the PC, issues one request at a time on the
// req/gnt/rvalid bus and hands each surviving instruction to the IF/ID register.
module if_fetch #(
  parameter int                   AddrWidth = 32,
  parameter int                   DataWidth = 32,
  parameter logic [AddrWidth-1:0] ResetPc   = AddrWidth'(32'h0000_0000),
  parameter logic [DataWidth-1:0] NopInst   = DataWidth'(32'h0000_0013)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 jump_flag_i,
  input  logic [AddrWidth-1:0] jump_addr_i,
  input  logic                 hold_flag_i,
  output logic                 ibus_req_o,
  output logic [AddrWidth-1:0] ibus_addr_o,
  input  logic                 ibus_gnt_i,
  input  logic                 ibus_rvalid_i,
  input  logic [DataWidth-1:0] ibus_rdata_i,
  output logic [DataWidth-1:0] inst_o,
  output logic [AddrWidth-1:0] inst_addr_o,
  output logic                 inst_valid_o,
  output logic                 if_hold_o
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HELD
  } state_e;

  localparam logic [AddrWidth-1:0] PcStep = AddrWidth'(4);

  state_e               state_q;
  logic [AddrWidth-1:0] pc_q;
  logic                 squash_q;
  logic [DataWidth-1:0] buf_q;

  // Gating with rst keeps the bus quiet from the moment reset is asserted,
  // not just from the first reset edge.
  assign ibus_req_o  = rst & (state_q == REQ);
  assign ibus_addr_o = pc_q;
  assign if_hold_o   = ~inst_valid_o;

  // NOTE: all state uses non-blocking assignments so every branch reads the
  // pre-edge pc_q/squash_q, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= ResetPc;
      squash_q     <= 1'b0;
      // NOTE: the holding buffer is a plain register, so it is reset with the
      // rest of the state; no stale word can ever leak out of HELD.
      buf_q        <= '0;
      inst_o       <= NopInst;
      inst_addr_o  <= ResetPc;
      inst_valid_o <= 1'b0;
    end else begin
      inst_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          if (jump_flag_i) pc_q <= jump_addr_i;
        end

        REQ: begin
          if (jump_flag_i) pc_q <= jump_addr_i;
          if (ibus_gnt_i) begin
            // A jump in the grant cycle means the accepted address is stale.
            state_q  <= WAIT;
            squash_q <= jump_flag_i;
          end
        end

        WAIT: begin
          if (ibus_rvalid_i) begin
            state_q  <= REQ;
            squash_q <= 1'b0;
            if (jump_flag_i) begin
              pc_q <= jump_addr_i;
            end else if (!squash_q) begin
              if (hold_flag_i) begin
                buf_q   <= ibus_rdata_i;
                state_q <= HELD;
              end else begin
                inst_o       <= ibus_rdata_i;
                inst_addr_o  <= pc_q;
                inst_valid_o <= 1'b1;
                pc_q         <= pc_q + PcStep;
              end
            end
          end else if (jump_flag_i) begin
            pc_q     <= jump_addr_i;
            squash_q <= 1'b1;
          end
        end

        HELD: begin
          if (jump_flag_i) begin
            pc_q    <= jump_addr_i;
            state_q <= REQ;
          end else if (!hold_flag_i) begin
            inst_o       <= buf_q;
            inst_addr_o  <= pc_q;
            inst_valid_o <= 1'b1;
            pc_q         <= pc_q + PcStep;
            state_q      <= REQ;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by random
// gnt/hold/jump traffic, all compared against a transaction-level model.
module tb_if_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic        hold_flag;
  logic        gnt;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic        if_hold;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic [31:0] w_inst;
  logic [31:0] w_inst_addr;
  logic        w_valid;
  logic        w_if_hold;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  if_fetch #(.ResetPc(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag), .jump_addr_i(jump_addr), .hold_flag_i(hold_flag),
    .ibus_req_o(ibus_req), .ibus_addr_o(ibus_addr), .ibus_gnt_i(gnt),
    .ibus_rvalid_i(ibus_rvalid), .ibus_rdata_i(ibus_rdata),
    .inst_o(inst), .inst_addr_o(inst_addr), .inst_valid_o(inst_valid),
    .if_hold_o(if_hold)
  );

  if_fetch #(.ResetPc(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .jump_flag_i(1'b0), .jump_addr_i(32'h0), .hold_flag_i(1'b0),
    .ibus_req_o(w_req), .ibus_addr_o(w_addr), .ibus_gnt_i(1'b1),
    .ibus_rvalid_i(w_rvalid), .ibus_rdata_i(w_rdata),
    .inst_o(w_inst), .inst_addr_o(w_inst_addr), .inst_valid_o(w_valid),
    .if_hold_o(w_if_hold)
  );

  // Bus responder for the main DUT: one response rv_delay cycles after each grant.
  int          rv_delay = 1;
  int          rv_cnt;
  logic [31:0] pend_data;
  logic        rv_inject;

  always @(posedge clk) begin
    if (!rst) begin
      rv_cnt <= 0;
    end else if (ibus_req && gnt) begin
      rv_cnt    <= rv_delay;
      pend_data <= ibus_addr ^ KEY;
    end else if (rv_cnt != 0) begin
      rv_cnt <= rv_cnt - 1;
    end
  end

  assign ibus_rvalid = (rv_cnt == 1) || rv_inject;
  assign ibus_rdata  = rv_inject ? 32'hDEAD_BEEF : pend_data;

  // Responder for the wrap-around instance (always granted, 1-cycle response).
  always @(posedge clk) begin
    if (!rst) begin
      w_rvalid <= 1'b0;
    end else begin
      w_rvalid <= w_req;
      w_rdata  <= w_addr ^ KEY;
    end
  end

  function automatic logic [31:0] b2w(input logic b);
    return {31'b0, b};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Transaction-level reference: each granted fetch is a transaction that is
  // delivered unless a jump happens between its grant and its delivery.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    bit          killed;
  } txn_t;

  txn_t        out_q[$];
  txn_t        arr;
  bit          arr_v;
  logic [31:0] exp_addr;
  logic [31:0] exp_inst;
  logic [31:0] exp_iaddr;
  logic        exp_valid;
  int          model_dcnt = 0;
  int          dut_vcnt   = 0;
  bit          mon_on     = 0;
  logic [31:0] wg_q[$];
  logic [31:0] wd_addr_q[$];
  logic [31:0] wd_data_q[$];

  initial begin
    forever begin
      @(posedge clk);
      if (rst && w_req && wg_q.size() < 4) wg_q.push_back(w_addr);
      if (!rst) begin
        out_q.delete();
        arr_v     = 0;
        exp_addr  = 32'h0;
        exp_inst  = NOP;
        exp_iaddr = 32'h0;
        exp_valid = 1'b0;
      end else begin
        txn_t t;
        exp_valid = 1'b0;
        if (ibus_req && gnt) out_q.push_back('{ibus_addr, ibus_addr ^ KEY, 1'b0});
        if (ibus_rvalid && out_q.size() > 0) begin
          t = out_q.pop_front();
          if (!t.killed && !jump_flag) begin
            arr      = t;
            arr_v    = 1;
            exp_addr = t.addr + 32'd4;
          end
        end
        if (jump_flag) begin
          foreach (out_q[i]) out_q[i].killed = 1'b1;
          arr_v    = 0;
          exp_addr = jump_addr;
        end
        if (arr_v && !hold_flag) begin
          exp_valid = 1'b1;
          exp_inst  = arr.data;
          exp_iaddr = arr.addr;
          arr_v     = 0;
          model_dcnt++;
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (w_valid && wd_addr_q.size() < 4) begin
        wd_addr_q.push_back(w_inst_addr);
        wd_data_q.push_back(w_inst);
      end
      if (mon_on) begin
        if (inst_valid) dut_vcnt++;
        if (!rst) check("req_in_reset", b2w(ibus_req), 32'h0);
        check("inst_valid", b2w(inst_valid), b2w(exp_valid));
        check("if_hold", b2w(if_hold), b2w(~exp_valid));
        check("inst", inst, exp_inst);
        check("inst_addr", inst_addr, exp_iaddr);
        if (ibus_req) begin
          check("fetch_addr", ibus_addr, exp_addr);
          check("one_outstanding", b2w(out_q.size() != 0 || arr_v), 32'h0);
        end
      end
    end
  end

  task automatic wait_req(input int budget, input string tag, output int stale);
    int n = 0;
    stale = 0;
    while (ibus_req !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
      if (inst_valid === 1'b1) stale++;
    end
    check({tag, "_req_seen"}, b2w(ibus_req), 32'h1);
  endtask

  task automatic next_valid(input int budget, input string tag, output int gap);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (inst_valid !== 1'b1 && gap < budget);
    check({tag, "_valid_seen"}, b2w(inst_valid), 32'h1);
  endtask

  initial begin
    int lat;
    int gap;
    int stale;
    rst = 1'b0; jump_flag = 1'b0; jump_addr = 32'h0; hold_flag = 1'b0;
    gnt = 1'b1; rv_inject = 1'b0;

    // 1: reset, then back-to-back fetches at 0x0, 0x4, 0x8
    @(posedge clk);
    mon_on = 1;
    repeat (3) @(negedge clk);
    check("rst_inst", inst, NOP);
    check("rst_inst_addr", inst_addr, 32'h0);
    check("rst_valid", b2w(inst_valid), 32'h0);
    check("rst_req", b2w(ibus_req), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("t1_first_req", b2w(ibus_req), 32'h1);
    check("t1_first_addr", ibus_addr, 32'h0);
    lat = 1;
    while (inst_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("t1_latency", lat, 32'd3);
    check("t1_addr0", inst_addr, 32'h0);
    check("t1_data0", inst, KEY);
    for (int k = 1; k < 3; k++) begin
      next_valid(10, "t1", gap);
      check("t1_gap", gap, 32'd2);
      check("t1_addr", inst_addr, 32'(4 * k));
      check("t1_data", inst, 32'(4 * k) ^ KEY);
    end

    // 2: grant withheld, request held stable
    gnt = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t2_req", b2w(ibus_req), 32'h1);
      check("t2_addr", ibus_addr, 32'h0000_000C);
      check("t2_valid", b2w(inst_valid), 32'h0);
    end

    // 3: jump while waiting on the response
    rv_delay = 3;
    gnt = 1'b1;
    @(negedge clk);
    check("t3_in_wait", b2w(ibus_req), 32'h0);
    jump_flag = 1'b1;
    jump_addr = 32'h0000_0100;
    @(negedge clk);
    jump_flag = 1'b0;
    wait_req(10, "t3", stale);
    check("t3_stale_valid", stale, 32'd0);
    check("t3_redirect_addr", ibus_addr, 32'h0000_0100);
    rv_delay = 1;
    next_valid(10, "t3", gap);
    check("t3_inst_addr", inst_addr, 32'h0000_0100);
    check("t3_inst", inst, 32'h0000_0100 ^ KEY);

    // 4: hold when the response arrives, then release
    hold_flag = 1'b1;
    @(negedge clk);
    check("t4_wait_valid", b2w(inst_valid), 32'h0);
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      check("t4_held_valid", b2w(inst_valid), 32'h0);
      check("t4_held_if_hold", b2w(if_hold), 32'h1);
      check("t4_held_req", b2w(ibus_req), 32'h0);
    end
    hold_flag = 1'b0;
    @(negedge clk);
    check("t4_release_valid", b2w(inst_valid), 32'h1);
    check("t4_release_addr", inst_addr, 32'h0000_0104);
    check("t4_release_inst", inst, 32'h0000_0104 ^ KEY);
    check("t4_next_req", b2w(ibus_req), 32'h1);
    check("t4_next_addr", ibus_addr, 32'h0000_0108);

    // 5: ResetPc at the top of the address space wraps to 0
    check("t5_fetches", b2w(wg_q.size() >= 2 && wd_addr_q.size() >= 2), 32'h1);
    if (wg_q.size() >= 2 && wd_addr_q.size() >= 2) begin
      check("t5_fetch0", wg_q[0], 32'hFFFF_FFFC);
      check("t5_fetch1", wg_q[1], 32'h0000_0000);
      check("t5_deliv0_addr", wd_addr_q[0], 32'hFFFF_FFFC);
      check("t5_deliv0_data", wd_data_q[0], 32'h5A5A_FFFC);
      check("t5_deliv1_addr", wd_addr_q[1], 32'h0000_0000);
      check("t5_deliv1_data", wd_data_q[1], KEY);
    end

    // 6: reset while in WAIT, rvalid pulsed during reset
    rv_delay = 3;
    @(negedge clk);
    check("t6_in_wait", b2w(ibus_req), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    rv_inject = 1'b1;
    @(negedge clk);
    rv_inject = 1'b0;
    @(negedge clk);
    check("t6_rst_valid", b2w(inst_valid), 32'h0);
    check("t6_rst_inst", inst, NOP);
    check("t6_rst_inst_addr", inst_addr, 32'h0);
    rv_delay = 1;
    rst = 1'b1;
    @(negedge clk);
    check("t6_refetch_req", b2w(ibus_req), 32'h1);
    check("t6_refetch_addr", ibus_addr, 32'h0);
    check("t6_inst_nop", inst, NOP);
    next_valid(10, "t6", gap);
    check("t6_first_addr", inst_addr, 32'h0);
    check("t6_first_inst", inst, KEY);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      gnt       = ($urandom_range(0, 3) != 0);
      hold_flag = ($urandom_range(0, 3) == 0);
      jump_flag = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       jump_addr = 32'hFFFF_FFF8;
        1:       jump_addr = 32'hFFFF_FFFC;
        default: jump_addr = $urandom & 32'hFFFF_FFFC;
      endcase
      rv_delay = $urandom_range(1, 3);
    end
    jump_flag = 1'b0;
    hold_flag = 1'b0;
    gnt       = 1'b1;
    rv_delay  = 1;
    repeat (10) @(negedge clk);
    check("rand_delivery_count", dut_vcnt, model_dcnt);
    check("rand_activity", b2w(model_dcnt > 50), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
